// File: rtl/srt2_prenorm_pkg.sv
// Shared constants and state encoding for the SRT radix-2 divider front end.
// Imported by the pre-normalisation stage, its interface and the divider.
// SW is derived from W so that a shift of up to W-1 always fits.
package srt2_prenorm_pkg;

  localparam int W  = 16;
  // Smallest width holding W-1 with margin: 2**SW > W-1 for any W.
  localparam int SW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/srt2_prenorm_if.sv
// Operand/result bundle between the operand source, pre-normaliser and divider.
// master drives operands and out_ready; slave is the pre-normalisation stage.
// Widths come from the shared package so both sides always agree.
interface srt2_prenorm_if;
  import srt2_prenorm_pkg::*;

  logic              load;
  logic [W-1:0]      Divident;
  logic [W-1:0]      Divisor;
  logic              ready;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      norm_divisor;
  logic [2*W-1:0]    norm_dividend;
  logic [SW-1:0]     shift;
  logic              div_zero;

  modport master (
    output load, Divident, Divisor, out_ready,
    input  ready, out_valid, norm_divisor, norm_dividend, shift, div_zero
  );

  modport slave (
    input  load, Divident, Divisor, out_ready,
    output ready, out_valid, norm_divisor, norm_dividend, shift, div_zero
  );

endinterface

// File: rtl/srt2_prenorm.sv
// Pre-normalises divisor (MSB to 1) one left shift per cycle, dividend in lockstep.
// Latency k+1 cycles for k divisor leading zeros; 1 cycle for a zero divisor.
// Result held in DONE until out_ready; ready follows out_ready there for back-to-back loads.
module srt2_prenorm
  import srt2_prenorm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  srt2_prenorm_if.slave    bus
);

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_divisor;
  logic [2*W-1:0]  r_dividend;
  logic [SW-1:0]   r_shift;
  logic            r_div_zero;

  logic            w_ready;
  logic            w_valid;
  logic            w_capture;
  logic            w_zero;
  logic            w_msb;

  assign w_zero    = (r_divisor == '0);
  assign w_msb     = r_divisor[W-1];
  assign w_capture = bus.load & w_ready;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: normalise until the divisor MSB is set or the divisor is zero.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.load) w_next = NORM;
      end
      NORM: begin
        if (w_zero || w_msb) w_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) w_next = bus.load ? NORM : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs; ready in DONE passes out_ready through so a new pair can
  // be captured on the same edge the current result is taken.
  always_comb begin
    w_ready = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      IDLE:    w_ready = 1'b1;
      NORM:    w_ready = 1'b0;
      DONE: begin
        w_ready = bus.out_ready;
        w_valid = 1'b1;
      end
      default: w_ready = 1'b0;
    endcase
  end

  // Operand registers: capture on load, then one shared left shift per NORM cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_divisor  <= '0;
      r_dividend <= '0;
      r_shift    <= '0;
      r_div_zero <= 1'b0;
    end else if (w_capture) begin
      r_divisor  <= bus.Divisor;
      r_dividend <= {{W{1'b0}}, bus.Divident};
      r_shift    <= '0;
      r_div_zero <= 1'b0;
    end else if (r_state == NORM) begin
      if (w_zero) begin
        // Divide-by-zero: flag it and present an all-zero data word.
        r_dividend <= '0;
        r_shift    <= '0;
        r_div_zero <= 1'b1;
      end else if (!w_msb) begin
        r_divisor  <= r_divisor << 1;
        r_dividend <= r_dividend << 1;
        r_shift    <= r_shift + SW'(1);
      end
    end
  end

  assign bus.ready         = w_ready;
  assign bus.out_valid     = w_valid;
  assign bus.norm_divisor  = r_divisor;
  assign bus.norm_dividend = r_dividend;
  assign bus.shift         = r_shift;
  assign bus.div_zero      = r_div_zero;

endmodule
